// File: rtl/tdc_code_averager.sv
// Batch averager for delay-line TDC codes: accumulates 2^LOG2_N in-range codes and
// presents mean/min/max over valid/ready, with saturating reject and drop counters.
module tdc_code_averager #(
   parameter int CODE_W   = 7,
   parameter int MAX_CODE = 86,
   parameter int LOG2_N   = 4,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_valid,
   output logic [CODE_W-1:0] result_mean,
   output logic [CODE_W-1:0] result_min,
   output logic [CODE_W-1:0] result_max,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [CNT_W-1:0]  reject_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int SUM_W = CODE_W + LOG2_N;
   localparam logic [LOG2_N:0]   N_SAMPLES = {1'b1, {LOG2_N{1'b0}}};
   localparam logic [CODE_W-1:0] MAX_CODE_C = CODE_W'(MAX_CODE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [LOG2_N:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]  min_q, min_d;
   logic [CODE_W-1:0]  max_q, max_d;
   logic [CODE_W-1:0]  mean_q, res_min_q, res_max_q;
   logic               valid_q;
   logic [CNT_W-1:0]   reject_q, reject_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               strobe_s;
   logic               in_range_s;

   // Candidate accumulator values with the current code folded in, plus saturating increments.
   always_comb begin
      strobe_s   = en & code_valid;
      in_range_s = (code_in <= MAX_CODE_C);
      sum_d      = sum_q + {{LOG2_N{1'b0}}, code_in};
      cnt_d      = cnt_q + {{LOG2_N{1'b0}}, 1'b1};
      if (code_in < min_q) begin
         min_d = code_in;
      end else begin
         min_d = min_q;
      end
      if (code_in > max_q) begin
         max_d = code_in;
      end else begin
         max_d = max_q;
      end
      if (reject_q == {CNT_W{1'b1}}) begin
         reject_d = reject_q;
      end else begin
         reject_d = reject_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (drop_q == {CNT_W{1'b1}}) begin
         drop_d = drop_q;
      end else begin
         drop_d = drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Control FSM with accumulator, result and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sum_q     <= {SUM_W{1'b0}};
         cnt_q     <= {(LOG2_N+1){1'b0}};
         min_q     <= {CODE_W{1'b1}};
         max_q     <= {CODE_W{1'b0}};
         mean_q    <= {CODE_W{1'b0}};
         res_min_q <= {CODE_W{1'b0}};
         res_max_q <= {CODE_W{1'b0}};
         valid_q   <= 1'b0;
         reject_q  <= {CNT_W{1'b0}};
         drop_q    <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (!en) begin
                  // Partial batch is thrown away.
                  state_q <= IDLE;
                  sum_q   <= {SUM_W{1'b0}};
                  cnt_q   <= {(LOG2_N+1){1'b0}};
                  min_q   <= {CODE_W{1'b1}};
                  max_q   <= {CODE_W{1'b0}};
               end else if (strobe_s) begin
                  if (!in_range_s) begin
                     reject_q <= reject_d;
                  end else if (cnt_d == N_SAMPLES) begin
                     mean_q    <= sum_d[SUM_W-1:LOG2_N];
                     res_min_q <= min_d;
                     res_max_q <= max_d;
                     valid_q   <= 1'b1;
                     state_q   <= HOLD;
                     sum_q     <= {SUM_W{1'b0}};
                     cnt_q     <= {(LOG2_N+1){1'b0}};
                     min_q     <= {CODE_W{1'b1}};
                     max_q     <= {CODE_W{1'b0}};
                  end else begin
                     sum_q <= sum_d;
                     cnt_q <= cnt_d;
                     min_q <= min_d;
                     max_q <= max_d;
                  end
               end
            end
            HOLD: begin
               if (strobe_s) begin
                  if (in_range_s) begin
                     drop_q <= drop_d;
                  end else begin
                     reject_q <= reject_d;
                  end
               end
               if (valid_q && result_ready) begin
                  valid_q <= 1'b0;
                  state_q <= en ? ACCUM : IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign result_mean  = mean_q;
   assign result_min   = res_min_q;
   assign result_max   = res_max_q;
   assign result_valid = valid_q;
   assign reject_cnt   = reject_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_tdc_code_averager.sv
// Directed bench for tdc_code_averager: stimulus pushes expected batch results into a
// queue and a negedge monitor pops and compares on every result handshake.
module tb_tdc_code_averager;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [6:0] code_in;
   logic       code_valid;
   logic [6:0] result_mean, result_min, result_max;
   logic       result_valid;
   logic       result_ready;
   logic [7:0] reject_cnt, drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int mean;
      int mn;
      int mx;
   } exp_t;
   exp_t exp_q[$];

   tdc_code_averager #(.CODE_W(7), .MAX_CODE(86), .LOG2_N(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .code_in      (code_in),
      .code_valid   (code_valid),
      .result_mean  (result_mean),
      .result_min   (result_min),
      .result_max   (result_max),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .reject_cnt   (reject_cnt),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [6:0] c);
      code_in    = c;
      code_valid = 1'b1;
      tick(1);
      code_valid = 1'b0;
   endtask

   task automatic push(input int m, input int mn, input int mx);
      exp_t e;
      e.mean = m;
      e.mn   = mn;
      e.mx   = mx;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: one comparison per accepted result.
   always @(negedge clk) begin
      if (!rst && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got mean %0d with no expected entry", result_mean);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_mean", int'(result_mean), e.mean);
            chk("mon_min",  int'(result_min),  e.mn);
            chk("mon_max",  int'(result_max),  e.mx);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; code_in = 7'd0; code_valid = 1'b0; result_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst_mean", int'(result_mean), 0);
      chk("rst_min", int'(result_min), 0);
      chk("rst_max", int'(result_max), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_reject", int'(reject_cnt), 0);
      chk("rst_drop", int'(drop_cnt), 0);

      // Strobe while still IDLE is ignored.
      en = 1'b1;
      strobe(7'd100);
      chk("idle_ignore_reject", int'(reject_cnt), 0);

      // Batch of 16 x 40
      push(40, 40, 40);
      for (int i = 0; i < 15; i++) strobe(7'd40);
      chk("b1_not_early", int'(result_valid), 0);
      strobe(7'd40);
      chk("b1_valid_latency", int'(result_valid), 1);
      tick(2);
      chk("b1_valid_cleared", int'(result_valid), 0);
      chk("b1_reject", int'(reject_cnt), 0);
      chk("b1_drop", int'(drop_cnt), 0);

      // Alternating 10/11, sum 168 truncates to 10
      push(10, 10, 11);
      for (int i = 0; i < 16; i++) strobe((i % 2 == 0) ? 7'd10 : 7'd11);
      tick(2);

      // 16 x 20 with three rejected 100s interleaved
      push(20, 20, 20);
      for (int i = 0; i < 19; i++) strobe((i == 4 || i == 9 || i == 14) ? 7'd100 : 7'd20);
      chk("b3_valid_after_19", int'(result_valid), 1);
      tick(2);
      chk("b3_reject", int'(reject_cnt), 3);

      // Held result: 15 x 1 plus MAX_CODE 86 -> sum 101, mean 6
      result_ready = 1'b0;
      push(6, 1, 86);
      for (int i = 0; i < 15; i++) strobe(7'd1);
      strobe(7'd86);
      for (int i = 0; i < 5; i++) strobe(7'd30);
      chk("hold_valid", int'(result_valid), 1);
      chk("hold_mean", int'(result_mean), 6);
      chk("hold_min", int'(result_min), 1);
      chk("hold_max", int'(result_max), 86);
      chk("hold_drop", int'(drop_cnt), 5);
      strobe(7'd87);
      chk("hold_reject_87", int'(reject_cnt), 4);
      result_ready = 1'b1;
      tick(1);
      chk("hs_valid_low", int'(result_valid), 0);
      chk("hs_mean_kept", int'(result_mean), 6);
      tick(1);

      // Partial batch discarded by en low
      for (int i = 0; i < 8; i++) strobe(7'd50);
      en = 1'b0;
      tick(1);
      en = 1'b1;
      tick(1);
      push(5, 5, 5);
      for (int i = 0; i < 16; i++) strobe(7'd5);
      tick(2);

      // Reject saturation then reset mid-batch
      for (int i = 0; i < 300; i++) strobe(7'd100);
      chk("reject_sat", int'(reject_cnt), 255);
      chk("drop_kept", int'(drop_cnt), 5);
      for (int i = 0; i < 5; i++) strobe(7'd7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst2_mean", int'(result_mean), 0);
      chk("rst2_max", int'(result_max), 0);
      chk("rst2_valid", int'(result_valid), 0);
      chk("rst2_reject", int'(reject_cnt), 0);
      chk("rst2_drop", int'(drop_cnt), 0);
      tick(1);
      push(7, 7, 7);
      for (int i = 0; i < 16; i++) strobe(7'd7);
      chk("b6_valid", int'(result_valid), 1);
      tick(3);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdc_code_averager.md
Name: tdc_code_averager

Overview:
- Downstream consumer of the 7-bit binary code from the delay-line TDC top level.
- Accepts one code per strobe, rejects codes outside the delay-line range, and accumulates 2^LOG2_N accepted codes.
- Emits the truncated mean plus the min and max code of the batch over a valid/ready handshake to the readout/host interface.
- Also keeps saturating reject and drop counters for line-health monitoring.

Parameters:
- CODE_W, 7, width of the incoming TDC code.
- MAX_CODE, 86, largest legal code (delay-line STAGES-1). Codes above this are rejected.
- LOG2_N, 4, batch size is N = 2^LOG2_N accepted samples.
- CNT_W, 8, width of the reject and drop counters.

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, block enable; same enable that gates the TDC front end.
- code_in, input, CODE_W, binary code from the TDC encoder.
- code_valid, input, 1, single-cycle strobe: code_in holds a new measurement.
- result_mean, output, CODE_W, batch sum >> LOG2_N (truncated).
- result_min, output, CODE_W, smallest accepted code in the batch.
- result_max, output, CODE_W, largest accepted code in the batch.
- result_valid, output, 1, result fields valid.
- result_ready, input, 1, consumer accepts the result.
- reject_cnt, output, CNT_W, saturating count of out-of-range codes.
- drop_cnt, output, CNT_W, saturating count of in-range codes lost while in HOLD.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator sum 0; sample counter 0; min register all-ones; max register 0.
- Sum width is CODE_W+LOG2_N, so it never overflows for N legal codes. The sample counter is LOG2_N+1 bits.
- A strobe is a cycle with en=1 and code_valid=1.
- IDLE:
  - en=1 → ACCUM next cycle.
  - Strobes seen in IDLE are ignored; no counters change.
- ACCUM, per strobe:
  - code_in > MAX_CODE: reject_cnt += 1 (saturating at all-ones). Sum, count, min and max are unchanged.
  - Otherwise: sum += code_in, count += 1, min = min(min, code_in), max = max(max, code_in).
  - When the N-th accepted sample arrives at cycle t: result registers load at edge t+1 from the updated values. result_valid=1 from cycle t+1. State → HOLD. Sum, count, min and max are reinitialised in the same edge.
- HOLD:
  - result_* and result_valid are stable until handshake.
  - An in-range strobe increments drop_cnt (saturating). An out-of-range strobe increments reject_cnt. Neither is accumulated.
  - Handshake: result_valid & result_ready at an edge → result_valid=0 next cycle. State → ACCUM if en=1, else IDLE.
  - result_mean, result_min and result_max keep their last values after handshake.
- result_ready is ignored when result_valid=0.
- en=0 in ACCUM: next state IDLE; the partial batch is discarded (sum, count, min and max reinitialised).
- en=0 in HOLD: the result stays valid and the handshake completes normally, then the block goes to IDLE.
- rst in any state returns all state to reset values in the next cycle. A pending result is lost. Counters clear.
- Counters are cleared only by rst.
- Throughput: a new batch can start accumulating the cycle after handshake. A strobe in the handshake cycle itself counts as a HOLD strobe (dropped).

Test Plan:
- rst, en=1, 16 strobes of code 40 on consecutive cycles, result_ready=1 → result_valid pulses 1 cycle after the 16th strobe; mean=40, min=40, max=40; reject_cnt=0, drop_cnt=0.
- 16 strobes alternating 10,11 (sum 168) → mean=10 (truncation), min=10, max=11.
- 3 strobes of code 100 interleaved in a batch of 16 codes of 20 → reject_cnt=3; result appears after 19 strobes with mean=20.
- Complete a batch with result_ready=0, then 5 strobes of code 30 → result_valid stays 1 with unchanged fields; drop_cnt=5. Raise result_ready → result_valid=0 next cycle; the next batch starts from empty.
- 8 strobes of code 50, drop en for 1 cycle, raise en, then 16 strobes of code 5 → mean=5, max=5 (partial batch discarded).
- 300 out-of-range strobes → reject_cnt saturates at 255. Then assert rst mid-batch → all outputs 0 the next cycle; the next full batch of 16×7 gives mean=7.
